// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake and ALU operand/result bundle for alu_issue_ctrl.
// slave is the controller's view; master is the issue stage / ALU side.
interface alu_issue_ctrl_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [6:0]      req_opcode;
    logic [2:0]      req_funct3;
    logic [6:0]      req_funct7;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [XLEN-1:0] req_imm;

    logic [2:0]      alu_funct;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_overflow;
    logic            alu_equal;
    logic            alu_less;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_taken;
    logic            rsp_illegal;
    logic            rsp_trap;

    modport slave (
        input  req_valid, req_opcode, req_funct3, req_funct7, req_rs1, req_rs2, req_imm,
        output req_ready,
        output alu_funct, alu_a, alu_b,
        input  alu_result, alu_overflow, alu_equal, alu_less,
        output rsp_valid, rsp_result, rsp_taken, rsp_illegal, rsp_trap,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_opcode, req_funct3, req_funct7, req_rs1, req_rs2, req_imm,
        input  req_ready,
        input  alu_funct, alu_a, alu_b,
        output alu_result, alu_overflow, alu_equal, alu_less,
        input  rsp_valid, rsp_result, rsp_taken, rsp_illegal, rsp_trap,
        output rsp_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// RV64I issue front end for the 3-bit-funct ALU: decode, operand registers, result capture.
// Optional macro ALU_OVF_TRAP_EN enables the signed-overflow trap on ADD/SUB/ADDI.
module alu_issue_ctrl #(
    parameter int XLEN = 64
) (
    input  logic           clk,
    input  logic           reset,
    alu_issue_ctrl_if.slave bus
);
    localparam logic [2:0] F_SUM  = 3'd0;
    localparam logic [2:0] F_SHL  = 3'd1;
    localparam logic [2:0] F_SUB  = 3'd2;
    localparam logic [2:0] F_LOAD = 3'd3;
    localparam logic [2:0] F_XOR  = 3'd4;
    localparam logic [2:0] F_SHR  = 3'd5;
    localparam logic [2:0] F_AND  = 3'd7;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q;
    logic [2:0]      alu_funct_q;
    logic [XLEN-1:0] alu_a_q, alu_b_q, rsp_result_q;
    logic            req_ready_q, rsp_valid_q, rsp_taken_q, rsp_illegal_q;
    logic            branch_q;
    logic [2:0]      br_f3_q;

    logic [2:0]      funct_d;
    logic [XLEN-1:0] a_d, b_d;
    logic            illegal_d, branch_d, ovf_sel_d, taken_d;

    always_comb begin
        funct_d   = F_LOAD;
        a_d       = '0;
        b_d       = '0;
        illegal_d = 1'b0;
        branch_d  = 1'b0;
        ovf_sel_d = 1'b0;
        case (bus.req_opcode)
            OP_R: begin
                a_d = bus.req_rs1;
                b_d = bus.req_rs2;
                if (bus.req_funct7 == 7'b0000000) begin
                    case (bus.req_funct3)
                        3'b000:  begin funct_d = F_SUM; ovf_sel_d = 1'b1; end
                        3'b001:  funct_d = F_SHL;
                        3'b100:  funct_d = F_XOR;
                        3'b101:  funct_d = F_SHR;
                        3'b111:  funct_d = F_AND;
                        default: illegal_d = 1'b1;
                    endcase
                end else if (bus.req_funct7 == 7'b0100000 && bus.req_funct3 == 3'b000) begin
                    funct_d   = F_SUB;
                    ovf_sel_d = 1'b1;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OP_I: begin
                a_d = bus.req_rs1;
                b_d = bus.req_imm;
                case (bus.req_funct3)
                    3'b000: begin funct_d = F_SUM; ovf_sel_d = 1'b1; end
                    3'b001, 3'b101: begin
                        // Only logical shifts exist in the ALU, so SRAI (funct6 != 0) is rejected.
                        if (bus.req_funct7[6:1] == 6'd0) begin
                            funct_d = (bus.req_funct3 == 3'b001) ? F_SHL : F_SHR;
                            b_d     = {{(XLEN-6){1'b0}}, bus.req_imm[5:0]};
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                    3'b100:  funct_d = F_XOR;
                    3'b111:  funct_d = F_AND;
                    default: illegal_d = 1'b1;
                endcase
            end
            OP_LD, OP_ST: begin
                funct_d = F_SUM;
                a_d     = bus.req_rs1;
                b_d     = bus.req_imm;
            end
            OP_BR: begin
                funct_d  = F_SUB;
                a_d      = bus.req_rs1;
                b_d      = bus.req_rs2;
                branch_d = 1'b1;
                if (bus.req_funct3 == 3'b010 || bus.req_funct3 == 3'b011 ||
                    bus.req_funct3 == 3'b110 || bus.req_funct3 == 3'b111)
                    illegal_d = 1'b1;
            end
            OP_LUI: begin
                funct_d = F_LOAD;
                a_d     = bus.req_imm;
            end
            default: illegal_d = 1'b1;
        endcase
        // Illegal encodings park the ALU on LOAD(0,0) so nothing stale leaks into it.
        if (illegal_d) begin
            funct_d   = F_LOAD;
            a_d       = '0;
            b_d       = '0;
            branch_d  = 1'b0;
            ovf_sel_d = 1'b0;
        end
    end

    always_comb begin
        taken_d = 1'b0;
        case (br_f3_q)
            3'b000:  taken_d =  bus.alu_equal;
            3'b001:  taken_d = !bus.alu_equal;
            3'b100:  taken_d =  bus.alu_less;
            3'b101:  taken_d = !bus.alu_less;
            default: taken_d = 1'b0;
        endcase
        taken_d = taken_d & branch_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            alu_funct_q   <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            rsp_result_q  <= '0;
            rsp_taken_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            branch_q      <= 1'b0;
            br_f3_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    alu_funct_q <= funct_d;
                    alu_a_q     <= a_d;
                    alu_b_q     <= b_d;
                    branch_q    <= branch_d;
                    br_f3_q     <= bus.req_funct3;
                    req_ready_q <= 1'b0;
                    if (illegal_d) begin
                        state_q       <= RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_result_q  <= '0;
                        rsp_taken_q   <= 1'b0;
                        rsp_illegal_q <= 1'b1;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_q  <= bus.alu_result;
                    rsp_taken_q   <= taken_d;
                    rsp_illegal_q <= 1'b0;
                    rsp_valid_q   <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ALU_OVF_TRAP_EN
    logic ovf_sel_q, rsp_trap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sel_q  <= 1'b0;
            rsp_trap_q <= 1'b0;
        end else if (state_q == IDLE && bus.req_valid) begin
            ovf_sel_q  <= ovf_sel_d;
            rsp_trap_q <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_trap_q <= ovf_sel_q & bus.alu_overflow;
        end
    end

    assign bus.rsp_trap = rsp_trap_q;
`else
    logic unused_ovf;
    assign unused_ovf   = bus.alu_overflow | ovf_sel_d;
    assign bus.rsp_trap = 1'b0;
`endif

    assign bus.req_ready   = req_ready_q;
    assign bus.alu_funct   = alu_funct_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_taken   = rsp_taken_q;
    assign bus.rsp_illegal = rsp_illegal_q;
endmodule
